hazard_stall_ctrl: RTL and testbench

//  Pipeline stall/flush controller for the 5-stage core; companion to the EX/MEM->EX/D forwarding unit.

---
 rtl/hazard_stall_ctrl_if.sv | 45 ++++
 rtl/hazard_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard-control bus: ID/EX hazard inputs and memory busy in, stall/flush/bubble controls
// and performance counters out. The pipeline side is master and the controller is slave.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] dec_ReadReg1;
  logic [REG_W-1:0] dec_ReadReg2;
  logic             dec_Uses1;
  logic             dec_Uses2;
  logic             exe_Valid;
  logic             exe_RegWrite;
  logic             exe_DMemEn;
  logic             exe_DMemWrite;
  logic [REG_W-1:0] exe_WriteReg;
  logic             exe_BrTaken;
  logic             exe_Halt;
  logic             mem_Busy;
  logic             pc_Stall;
  logic             ifid_Stall;
  logic             ifid_Flush;
  logic             idex_Stall;
  logic             idex_Bubble;
  logic             exmem_Stall;
  logic             memwb_Bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_Cnt;
  logic [CNT_W-1:0] flush_Cnt;

  modport master (
    output dec_ReadReg1, dec_ReadReg2, dec_Uses1, dec_Uses2,
           exe_Valid, exe_RegWrite, exe_DMemEn, exe_DMemWrite, exe_WriteReg,
           exe_BrTaken, exe_Halt, mem_Busy,
    input  pc_Stall, ifid_Stall, ifid_Flush, idex_Stall, idex_Bubble,
           exmem_Stall, memwb_Bubble, halted, stall_Cnt, flush_Cnt
  );

  modport slave (
    input  dec_ReadReg1, dec_ReadReg2, dec_Uses1, dec_Uses2,
           exe_Valid, exe_RegWrite, exe_DMemEn, exe_DMemWrite, exe_WriteReg,
           exe_BrTaken, exe_Halt, mem_Busy,
    output pc_Stall, ifid_Stall, ifid_Flush, idex_Stall, idex_Bubble,
           exmem_Stall, memwb_Bubble, halted, stall_Cnt, flush_Cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubble, taken-branch flush, data-memory
// freeze, HALT drain, plus saturating stall and flush counters. Controls are combinational.
module hazard_stall_ctrl #(
  parameter int REG_W     = 3,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {RUN = 2'd0, MEMW = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [REG_W-1:0] wr_reg, rd_reg1, rd_reg2;
  logic load_use, flush_inc;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble;

  assign wr_reg  = bus.exe_WriteReg;
  assign rd_reg1 = bus.dec_ReadReg1;
  assign rd_reg2 = bus.dec_ReadReg2;

  assign load_use = bus.exe_Valid & bus.exe_RegWrite & bus.exe_DMemEn & ~bus.exe_DMemWrite &
                    ((bus.dec_Uses1 & (wr_reg == rd_reg1)) | (bus.dec_Uses2 & (wr_reg == rd_reg2)));

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    flush_inc    = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    case (state_q)
      RUN, MEMW: begin
        // EX is frozen while memory is busy, so branch/halt/load-use are re-evaluated afterwards.
        if (bus.mem_Busy) begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_stall  = 1'b1;
          memwb_bubble = 1'b1;
          state_d      = MEMW;
        end else if (bus.exe_BrTaken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          state_d     = RUN;
        end else if (bus.exe_Halt) begin
          pc_stall    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          drain_d     = '0;
          state_d     = DRAIN;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        pc_stall    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (bus.mem_Busy) begin
          exmem_stall  = 1'b1;
          memwb_bubble = 1'b1;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = HALT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      HALT: begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Controls are forced quiet for as long as reset is held, whatever the hazard inputs say.
    if (!rst_n) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_stall   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_stall  = 1'b0;
      memwb_bubble = 1'b0;
      flush_inc    = 1'b0;
    end
    stall_cnt_d = (pc_stall && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_Stall     = pc_stall;
  assign bus.ifid_Stall   = ifid_stall;
  assign bus.ifid_Flush   = ifid_flush;
  assign bus.idex_Stall   = idex_stall;
  assign bus.idex_Bubble  = idex_bubble;
  assign bus.exmem_Stall  = exmem_stall;
  assign bus.memwb_Bubble = memwb_bubble;
  assign bus.halted       = rst_n & (state_q == HALT);
  assign bus.stall_Cnt    = stall_cnt_q;
  assign bus.flush_Cnt    = flush_cnt_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, forwarding cases, branch flush, memory freeze,
// HALT drain, reset recovery and counter saturation on a 4-bit-counter instance.
module tb_hazard_stall_ctrl;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_m, dbg_s;
  int errors = 0;
  int checks = 0;

  // control vector order: pc_Stall, ifid_Stall, ifid_Flush, idex_Stall, idex_Bubble, exmem_Stall, memwb_Bubble
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_LDUSE  = 7'b1100100;
  localparam logic [6:0] C_BRANCH = 7'b0010100;
  localparam logic [6:0] C_DRAIN  = 7'b1010100;
  localparam logic [6:0] C_DRBUSY = 7'b1010111;
  localparam logic [6:0] C_FREEZE = 7'b1101011;

  hazard_stall_ctrl_if #(.REG_W(3), .CNT_W(16)) m_if ();
  hazard_stall_ctrl_if #(.REG_W(3), .CNT_W(4))  s_if ();

  hazard_stall_ctrl #(.REG_W(3), .DRAIN_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if), .dbg_state(dbg_m));
  hazard_stall_ctrl #(.REG_W(3), .DRAIN_CYC(2), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(s_if), .dbg_state(dbg_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_m();
    return {m_if.pc_Stall, m_if.ifid_Stall, m_if.ifid_Flush, m_if.idex_Stall,
            m_if.idex_Bubble, m_if.exmem_Stall, m_if.memwb_Bubble};
  endfunction

  task automatic drive_idle();
    m_if.dec_ReadReg1 = '0; m_if.dec_ReadReg2 = '0; m_if.dec_Uses1 = 0; m_if.dec_Uses2 = 0;
    m_if.exe_Valid = 0; m_if.exe_RegWrite = 0; m_if.exe_DMemEn = 0; m_if.exe_DMemWrite = 0;
    m_if.exe_WriteReg = '0; m_if.exe_BrTaken = 0; m_if.exe_Halt = 0; m_if.mem_Busy = 0;
    s_if.dec_ReadReg1 = '0; s_if.dec_ReadReg2 = '0; s_if.dec_Uses1 = 0; s_if.dec_Uses2 = 0;
    s_if.exe_Valid = 0; s_if.exe_RegWrite = 0; s_if.exe_DMemEn = 0; s_if.exe_DMemWrite = 0;
    s_if.exe_WriteReg = '0; s_if.exe_BrTaken = 0; s_if.exe_Halt = 0; s_if.mem_Busy = 0;
  endtask

  // EX instruction: valid, writes wr; is_mem/is_store select load/store/ALU; ID reads r1/r2.
  task automatic drive_ex(input logic [2:0] wr, input logic is_mem, input logic is_store,
                          input logic [2:0] r1, input logic u1, input logic [2:0] r2, input logic u2);
    m_if.exe_Valid = 1; m_if.exe_RegWrite = 1; m_if.exe_WriteReg = wr;
    m_if.exe_DMemEn = is_mem; m_if.exe_DMemWrite = is_store;
    m_if.dec_ReadReg1 = r1; m_if.dec_Uses1 = u1; m_if.dec_ReadReg2 = r2; m_if.dec_Uses2 = u2;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    tick();
    checks++; if (ctl_m() !== C_IDLE) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl_m(), C_IDLE); end
    checks++; if (m_if.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", m_if.halted); end
    checks++; if (m_if.stall_Cnt !== 16'd0 || m_if.flush_Cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", m_if.stall_Cnt, m_if.flush_Cnt); end
    checks++; if (dbg_m !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_m); end
    rst_n = 1'b1;
    tick();
    checks++; if (ctl_m() !== C_IDLE || dbg_m !== 2'd0) begin errors++;
      $display("FAIL reset_release: got %b/%0d want %b/0", ctl_m(), dbg_m, C_IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_ex(3'd3, 1, 0, 3'd3, 1, 3'd5, 0);
    #1;
    checks++; if (ctl_m() !== C_LDUSE) begin errors++; $display("FAIL lduse_rs: got %b want %b", ctl_m(), C_LDUSE); end
    tick();
    drive_idle();
    #1;
    checks++; if (ctl_m() !== C_IDLE) begin errors++; $display("FAIL lduse_after: got %b want %b", ctl_m(), C_IDLE); end
    checks++; if (m_if.stall_Cnt !== 16'd1) begin errors++; $display("FAIL lduse_cnt: got %0d want 1", m_if.stall_Cnt); end
    drive_ex(3'd6, 1, 0, 3'd1, 1, 3'd6, 1);
    #1;
    checks++; if (ctl_m() !== C_LDUSE) begin errors++; $display("FAIL lduse_rt: got %b want %b", ctl_m(), C_LDUSE); end
    tick();
    drive_idle();
    #1;
    checks++; if (m_if.stall_Cnt !== 16'd2) begin errors++; $display("FAIL lduse_cnt2: got %0d want 2", m_if.stall_Cnt); end
  endtask

  task automatic test_no_stall();
    logic [6:0] got;
    do_reset();
    drive_ex(3'd3, 1, 1, 3'd3, 1, 3'd3, 1);  // store
    #1; got = ctl_m();
    checks++; if (got !== C_IDLE) begin errors++; $display("FAIL nostall_store: got %b want %b", got, C_IDLE); end
    drive_ex(3'd3, 1, 0, 3'd3, 0, 3'd3, 0);  // load, match but unused
    #1; got = ctl_m();
    checks++; if (got !== C_IDLE) begin errors++; $display("FAIL nostall_unused: got %b want %b", got, C_IDLE); end
    drive_ex(3'd3, 0, 0, 3'd3, 1, 3'd3, 1);  // ALU op, forwarded
    #1; got = ctl_m();
    checks++; if (got !== C_IDLE) begin errors++; $display("FAIL nostall_alu: got %b want %b", got, C_IDLE); end
    drive_ex(3'd3, 1, 0, 3'd4, 1, 3'd2, 1);  // load, no register match
    #1; got = ctl_m();
    checks++; if (got !== C_IDLE) begin errors++; $display("FAIL nostall_nomatch: got %b want %b", got, C_IDLE); end
    drive_ex(3'd3, 1, 0, 3'd3, 1, 3'd3, 1);
    m_if.exe_Valid = 0;                       // bubble in EX
    #1; got = ctl_m();
    checks++; if (got !== C_IDLE) begin errors++; $display("FAIL nostall_bubble: got %b want %b", got, C_IDLE); end
    tick();
    checks++; if (m_if.stall_Cnt !== 16'd0) begin errors++; $display("FAIL nostall_cnt: got %0d want 0", m_if.stall_Cnt); end
    drive_idle();
  endtask

  task automatic test_branch();
    do_reset();
    drive_ex(3'd3, 1, 0, 3'd3, 1, 3'd0, 0);
    m_if.exe_BrTaken = 1;
    #1;
    checks++; if (ctl_m() !== C_BRANCH) begin errors++; $display("FAIL branch_ctl: got %b want %b", ctl_m(), C_BRANCH); end
    tick();
    drive_idle();
    #1;
    checks++; if (m_if.flush_Cnt !== 16'd1 || m_if.stall_Cnt !== 16'd0) begin errors++;
      $display("FAIL branch_cnt: got %0d/%0d want 1/0", m_if.flush_Cnt, m_if.stall_Cnt); end
  endtask

  task automatic test_mem_busy();
    do_reset();
    m_if.exe_Valid = 1; m_if.exe_BrTaken = 1; m_if.mem_Busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl_m() !== C_FREEZE) begin errors++; $display("FAIL busy_ctl%0d: got %b want %b", i, ctl_m(), C_FREEZE); end
      tick();
      checks++; if (dbg_m !== 2'd1) begin errors++; $display("FAIL busy_state%0d: got %0d want 1", i, dbg_m); end
    end
    m_if.mem_Busy = 0;
    #1;
    checks++; if (ctl_m() !== C_BRANCH) begin errors++; $display("FAIL busy_flush: got %b want %b", ctl_m(), C_BRANCH); end
    tick();
    drive_idle();
    #1;
    checks++; if (m_if.stall_Cnt !== 16'd3 || m_if.flush_Cnt !== 16'd1) begin errors++;
      $display("FAIL busy_cnt: got %0d/%0d want 3/1", m_if.stall_Cnt, m_if.flush_Cnt); end
    checks++; if (dbg_m !== 2'd0 || ctl_m() !== C_IDLE) begin errors++;
      $display("FAIL busy_resume: got %0d/%b want 0/%b", dbg_m, ctl_m(), C_IDLE); end
  endtask

  task automatic test_halt();
    do_reset();
    m_if.exe_Valid = 1; m_if.exe_Halt = 1;
    #1;
    checks++; if (ctl_m() !== C_DRAIN) begin errors++; $display("FAIL halt_ctl: got %b want %b", ctl_m(), C_DRAIN); end
    tick();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl_m() !== C_DRAIN || m_if.halted !== 1'b0 || dbg_m !== 2'd2) begin errors++;
        $display("FAIL drain%0d: got %b/%b/%0d want %b/0/2", i, ctl_m(), m_if.halted, dbg_m, C_DRAIN); end
      tick();
    end
    #1;
    checks++; if (m_if.halted !== 1'b1 || ctl_m() !== C_FREEZE) begin errors++;
      $display("FAIL halted: got %b/%b want 1/%b", m_if.halted, ctl_m(), C_FREEZE); end
    m_if.exe_BrTaken = 1;  // must not leave HALT
    tick(); tick();
    checks++; if (m_if.halted !== 1'b1 || m_if.stall_Cnt !== 16'd5) begin errors++;
      $display("FAIL halt_hold: got %b/%0d want 1/5", m_if.halted, m_if.stall_Cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_if.halted !== 1'b0 || ctl_m() !== C_IDLE || m_if.stall_Cnt !== 16'd0 || dbg_m !== 2'd0) begin errors++;
      $display("FAIL halt_reset: got %b/%b/%0d/%0d want 0/%b/0/0", m_if.halted, ctl_m(), m_if.stall_Cnt, dbg_m, C_IDLE); end
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_halt_busy();
    do_reset();
    m_if.exe_Valid = 1; m_if.exe_Halt = 1;
    tick();
    drive_idle();
    m_if.mem_Busy = 1;
    #1;
    checks++; if (ctl_m() !== C_DRBUSY) begin errors++; $display("FAIL drbusy_ctl: got %b want %b", ctl_m(), C_DRBUSY); end
    tick();
    m_if.mem_Busy = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m_if.halted !== 1'b0 || dbg_m !== 2'd2) begin errors++;
        $display("FAIL drbusy_drain%0d: got %b/%0d want 0/2", i, m_if.halted, dbg_m); end
      tick();
    end
    #1;
    checks++; if (m_if.halted !== 1'b1 || m_if.stall_Cnt !== 16'd4) begin errors++;
      $display("FAIL drbusy_halted: got %b/%0d want 1/4", m_if.halted, m_if.stall_Cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_ex(3'd2, 1, 0, 3'd2, 1, 3'd0, 0);
    m_if.mem_Busy = 1;
    tick();
    checks++; if (dbg_m !== 2'd1) begin errors++; $display("FAIL midrst_pre: got %0d want 1", dbg_m); end
    m_if.mem_Busy = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (ctl_m() !== C_IDLE || dbg_m !== 2'd0) begin errors++;
      $display("FAIL midrst_ctl: got %b/%0d want %b/0", ctl_m(), dbg_m, C_IDLE); end
    tick();
    checks++; if (m_if.stall_Cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", m_if.stall_Cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (ctl_m() !== C_LDUSE) begin errors++; $display("FAIL midrst_after: got %b want %b", ctl_m(), C_LDUSE); end
    drive_idle();
  endtask

  task automatic test_saturate();
    do_reset();
    s_if.exe_Valid = 1; s_if.exe_RegWrite = 1; s_if.exe_DMemEn = 1; s_if.exe_WriteReg = 3'd1;
    s_if.dec_ReadReg1 = 3'd1; s_if.dec_Uses1 = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        checks++; if (s_if.stall_Cnt !== 4'hE) begin errors++; $display("FAIL sat_14: got %0h want e", s_if.stall_Cnt); end
      end
      if (i == 15 || i == 20) begin
        checks++; if (s_if.stall_Cnt !== 4'hF) begin errors++; $display("FAIL sat_%0d: got %0h want f", i, s_if.stall_Cnt); end
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_busy();
    test_halt();
    test_halt_busy();
    test_reset_mid_stall();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
